// File: rtl/fsm1_pkg.sv
// Shared types for the two-state toggle tracker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fsm1_pkg;

  // A and B are fixed to the values the output decode relies on: out == state bit.
  typedef enum logic {
    ST_A = 1'b0,
    ST_B = 1'b1
  } state_t;

  // Reset parks the tracker in B so out reads 1 while and after reset is applied.
  localparam state_t RESET_STATE = ST_B;

  // Default width of the optional transition counter.
  localparam int CNT_W_DEFAULT = 8;

endpackage : fsm1_pkg

// File: rtl/fsm1_sat_cnt.sv
// Saturating up-counter of state changes, built only with FSM1_TOGGLE_CNT_EN.
// Latency: count updates 1 clk after inc_i is sampled high; areset clears it at once.
// Backpressure: none; once all-ones, further increments are dropped.
`ifdef FSM1_TOGGLE_CNT_EN
module fsm1_sat_cnt
  import fsm1_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Step by one on request, holding at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register, cleared asynchronously together with the FSM.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : fsm1_sat_cnt
`endif

// File: rtl/top_module_fsm1.sv
// Two-state Moore toggle tracker: in=0 flips A<->B, in=1 holds; out=1 in B (FSM1_TOGGLE_CNT_EN adds a change counter).
// Latency: out reflects in 1 clk after sampling; areset forces B (out=1) without waiting for clk.
// Backpressure: none; in is sampled on every rising clk outside reset.
module top_module_fsm1
  import fsm1_pkg::*;
`ifdef FSM1_TOGGLE_CNT_EN
#(
  parameter int CNT_W = CNT_W_DEFAULT
)
`endif
(
  input  logic             clk,
  input  logic             areset,
  input  logic             in,
  output logic             out
`ifdef FSM1_TOGGLE_CNT_EN
  ,
  output logic [CNT_W-1:0] toggle_cnt
`endif
);

  state_t state_q;
  state_t state_d;

  // Next state: in=1 keeps the current state, in=0 moves to the other one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_A:    state_d = in ? ST_A : ST_B;
      ST_B:    state_d = in ? ST_B : ST_A;
      default: state_d = RESET_STATE;
    endcase
  end

  // Single state flop; areset wins over clk and in.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore decode straight from the flop, so in has no path to out.
  assign out = (state_q == ST_B);

`ifdef FSM1_TOGGLE_CNT_EN
  logic state_chg;

  assign state_chg = (state_d != state_q);

  fsm1_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_toggle_cnt (
    .clk    (clk),
    .areset (areset),
    .inc_i  (state_chg),
    .cnt_o  (toggle_cnt)
  );
`endif

endmodule : top_module_fsm1

// File: tb/tb_top_module_fsm1.sv
// Scoreboard bench for top_module_fsm1: parity-based reference model, queue of expected outputs.
// Expected out after each edge is 1 when the number of in=0 edges since reset is even.
// With FSM1_TOGGLE_CNT_EN the counter is built 2 bits wide so saturation is reached quickly.
module tb_top_module_fsm1;

  logic clk;
  logic areset;
  logic in;
  logic out;

`ifdef FSM1_TOGGLE_CNT_EN
  localparam int TB_CNT_W = 2;
  logic [TB_CNT_W-1:0] toggle_cnt;

  top_module_fsm1 #(
    .CNT_W (TB_CNT_W)
  ) dut (
    .clk        (clk),
    .areset     (areset),
    .in         (in),
    .out        (out),
    .toggle_cnt (toggle_cnt)
  );
`else
  top_module_fsm1 dut (
    .clk    (clk),
    .areset (areset),
    .in     (in),
    .out    (out)
  );
`endif

  typedef struct {
    bit          exp_out;
    int unsigned exp_cnt;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks;
  int          errors;
  int unsigned zeros;   // in=0 edges seen since the last reset

  // Posedges at 5, 15, 25, ...; negedges at 0, 10, 20, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Expected response derived purely from the count of toggling edges since reset.
  function automatic exp_t model_now();
    exp_t e;
    e.exp_out = ((zeros % 2) == 0);
`ifdef FSM1_TOGGLE_CNT_EN
    e.exp_cnt = (zeros > ((1 << TB_CNT_W) - 1)) ? ((1 << TB_CNT_W) - 1) : zeros;
`else
    e.exp_cnt = 0;
`endif
    return e;
  endfunction

  // One clock of stimulus: wiggle in during the low phase, settle to v, then predict.
  task automatic step(input logic v, input logic r);
    @(negedge clk);
    areset = r;
    in = ~v;
    #1 in = v;
    #1 in = ~v;
    #1 in = v;
    @(posedge clk);
    if (r) zeros = 0;
    else if (!v) zeros++;
    exp_q.push_back(model_now());
  endtask

  // Reset pulse placed between edges: out must go to 1 before the next edge.
  task automatic reset_pulse(input logic v);
    @(negedge clk);
    in = v;
    #1 areset = 1'b1;
    #1 chk("async_rst_out", {31'd0, out}, 32'd1);
`ifdef FSM1_TOGGLE_CNT_EN
    chk("async_rst_cnt", {30'd0, toggle_cnt}, 32'd0);
`endif
    #1 areset = 1'b0;
    zeros = 0;
    @(posedge clk);
    if (!v) zeros++;
    exp_q.push_back(model_now());
  endtask

  // Monitor: compare registered outputs shortly after every rising edge.
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("out", {31'd0, out}, {31'd0, mon_e.exp_out});
`ifdef FSM1_TOGGLE_CNT_EN
      chk("toggle_cnt", {30'd0, toggle_cnt}, mon_e.exp_cnt);
`endif
    end
  end

  // Outside reset, out may only move at a rising clk edge.
  always @(out) begin
    if (areset === 1'b0) begin
      chk("out_edge_aligned", $time % 10, 5);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    zeros  = 0;
    areset = 1'b1;
    in     = 1'b0;
    #1 chk("reset_out", {31'd0, out}, 32'd1);
`ifdef FSM1_TOGGLE_CNT_EN
    chk("reset_cnt", {30'd0, toggle_cnt}, 32'd0);
`endif

    // Reset held across edges with in=0: no transitions.
    repeat (3) step(1'b0, 1'b1);

    // Release and toggle five times: 0,1,0,1,0.
    repeat (5) step(1'b0, 1'b0);

    // Hold in A, then move to B and hold there.
    repeat (8) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    repeat (8) step(1'b1, 1'b0);

    // Into A, then reset between edges and toggle on the first edge after release.
    step(1'b0, 1'b0);
    reset_pulse(1'b0);
    step(1'b1, 1'b0);

    // Randomized run with occasional mid-cycle resets.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 19) == 0) reset_pulse(1'($urandom_range(0, 1)));
      else step(1'($urandom_range(0, 2) == 0), 1'b0);
    end

    // Let the monitor drain the queue, with a bounded wait.
    repeat (3) @(posedge clk);
    #4;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_top_module_fsm1
